// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector with elaboration-time KMP next-state table,
// input-enable gating and a saturating match counter.
//
// state   | meaning
// S0      | no pattern prefix matched yet
// Sk      | last k accepted bits equal the first k pattern bits (0 < k < PATTERN_W)
// S_MATCH | full pattern just accepted (k = PATTERN_W); detect is high
module seq_detect_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             clr_count,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic             sat
);

  localparam int SW     = $clog2(PATTERN_W + 1);
  localparam int N_ST   = 1 << SW;
  localparam int TBL_W  = 2 * N_ST * SW;

  localparam logic [SW-1:0] S0      = '0;
  localparam logic [SW-1:0] S_MATCH = SW'(PATTERN_W);

  // Pattern bit in arrival order: index 0 is the first bit received.
  function automatic logic pat_bit(input int i);
    return PATTERN[PATTERN_W-1-i];
  endfunction

  function automatic logic [SW-1:0] kmp_next(input int s, input logic b);
    logic [PATTERN_W:0] hist;
    int                 len;
    int                 best;
    logic               ok;
    hist = '0;
    for (int j = 0; j < PATTERN_W; j++) begin
      if (j < s) hist[j] = pat_bit(j);
    end
    hist[s] = b;
    len     = s + 1;
    best    = 0;
    for (int k = 1; k <= PATTERN_W; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int m = 0; m < PATTERN_W; m++) begin
          if (m < k && hist[len-k+m] != pat_bit(m)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return SW'(best);
  endfunction

  // Entry (2*s + b) holds the successor of state s on bit b; unreachable codes fall back to S0.
  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] t;
    int               sr;
    t = '0;
    for (int s = 0; s < N_ST; s++) begin
      for (int b = 0; b < 2; b++) begin
        if (s <= PATTERN_W) begin
          sr = (s == PATTERN_W && !OVERLAP) ? 0 : s;
          t[(2*s+b)*SW +: SW] = kmp_next(sr, 1'(b));
        end else begin
          t[(2*s+b)*SW +: SW] = S0;
        end
      end
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();

  logic [SW-1:0]    r_state;
  logic [SW-1:0]    w_state_nxt;
  logic             w_hit;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S0;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    if (en) begin
      w_state_nxt = NEXT_TBL[int'({r_state, x})*SW +: SW];
      w_hit       = (w_state_nxt == S_MATCH);
    end
  end

  // A match on the clearing edge counts as the first match after the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_hit) begin
      if (clr_count)     r_count <= CNT_W'(1);
      else if (!(&r_count)) r_count <= r_count + CNT_W'(1);
    end else if (clr_count) begin
      r_count <= '0;
    end
  end

  assign detect      = (r_state == S_MATCH);
  assign match_count = r_count;
  assign sat         = &r_count;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and randomised checks of seq_detect_param across five parameter sets
// driven from one shared stimulus stream.
module tb_seq_detect_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, x, en, clr_count;

  logic       det_ov, det_no, det_c2, det_t3o, det_t3n;
  logic [7:0] cnt_ov, cnt_no, cnt_t3o, cnt_t3n;
  logic [1:0] cnt_c2;
  logic       sat_ov, sat_no, sat_c2, sat_t3o, sat_t3n;

  int n_checks = 0;
  int n_errors = 0;

  seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr_count(clr_count),
    .detect(det_ov), .match_count(cnt_ov), .sat(sat_ov));
  seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr_count(clr_count),
    .detect(det_no), .match_count(cnt_no), .sat(sat_no));
  seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr_count(clr_count),
    .detect(det_c2), .match_count(cnt_c2), .sat(sat_c2));
  seq_detect_param #(.PATTERN_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(8)) u_t3o (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr_count(clr_count),
    .detect(det_t3o), .match_count(cnt_t3o), .sat(sat_t3o));
  seq_detect_param #(.PATTERN_W(3), .PATTERN(3'b111), .OVERLAP(1'b0), .CNT_W(8)) u_t3n (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr_count(clr_count),
    .detect(det_t3n), .match_count(cnt_t3n), .sat(sat_t3n));

  logic dut_det[5];
  int   dut_cnt[5];
  logic dut_sat[5];
  assign dut_det[0] = det_ov;  assign dut_cnt[0] = int'(cnt_ov);  assign dut_sat[0] = sat_ov;
  assign dut_det[1] = det_no;  assign dut_cnt[1] = int'(cnt_no);  assign dut_sat[1] = sat_no;
  assign dut_det[2] = det_c2;  assign dut_cnt[2] = int'(cnt_c2);  assign dut_sat[2] = sat_c2;
  assign dut_det[3] = det_t3o; assign dut_cnt[3] = int'(cnt_t3o); assign dut_sat[3] = sat_t3o;
  assign dut_det[4] = det_t3n; assign dut_cnt[4] = int'(cnt_t3n); assign dut_sat[4] = sat_t3n;

  // Reference model: sliding window of accepted bits, independent of any state table.
  int          m_w[5]   = '{4, 4, 4, 3, 3};
  logic [15:0] m_pat[5] = '{16'hD, 16'hD, 16'hD, 16'h7, 16'h7};
  bit          m_ovl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int          m_max[5] = '{255, 255, 3, 255, 255};
  logic [15:0] m_hist[5];
  int          m_nb[5];
  logic        m_det[5];
  int          m_cnt[5];

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_hist[i] = '0; m_nb[i] = 0; m_det[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input logic xb, input logic enb, input logic clr);
    logic [15:0] mask;
    logic        hit;
    for (int i = 0; i < 5; i++) begin
      hit = 1'b0;
      if (enb) begin
        m_hist[i] = {m_hist[i][14:0], xb};
        if (m_nb[i] < 100) m_nb[i]++;
        mask = 16'((32'd1 << m_w[i]) - 1);
        hit  = (m_nb[i] >= m_w[i]) && ((m_hist[i] & mask) == m_pat[i]);
        m_det[i] = hit;
        if (hit && !m_ovl[i]) m_nb[i] = 0;
      end
      if (hit)      m_cnt[i] = clr ? 1 : ((m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_cnt[i]);
      else if (clr) m_cnt[i] = 0;
    end
  endtask

  task automatic step(input logic xb, input logic enb, input logic clr);
    x = xb; en = enb; clr_count = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; x = 1'b0; en = 1'b0; clr_count = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] seq;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'(i % 2 == 0), 1'b1, 1'b0);
      n_checks++;
      if ({det_ov, det_no, det_t3o, det_t3n, cnt_ov, sat_ov, sat_c2} !== 13'd0) begin
        n_errors++;
        $display("FAIL reset_hold: det=%b%b%b%b cnt=%0d sat=%b%b required all zero",
                 det_ov, det_no, det_t3o, det_t3n, cnt_ov, sat_ov, sat_c2);
      end
    end
    rst = 1'b1;
    seq = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      step(seq[i], 1'b1, 1'b0);
      n_checks++;
      if (det_ov !== (i == 0)) begin
        n_errors++;
        $display("FAIL first_match_det bit%0d: got %b required %b", 4 - i, det_ov, (i == 0));
      end
    end
    n_checks++;
    if (cnt_ov !== 8'd1) begin
      n_errors++;
      $display("FAIL first_match_cnt: got %0d required 1", cnt_ov);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] seq;
    logic [6:0] exp_ov;
    logic [6:0] exp_no;
    seq    = 7'b1101101;
    exp_ov = 7'b0001001;
    exp_no = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(seq[i], 1'b1, 1'b0);
      n_checks++;
      if (det_ov !== exp_ov[i] || det_no !== exp_no[i]) begin
        n_errors++;
        $display("FAIL overlap_det bit%0d: got ov=%b no=%b required ov=%b no=%b",
                 7 - i, det_ov, det_no, exp_ov[i], exp_no[i]);
      end
    end
    n_checks++;
    if (cnt_ov !== 8'd2 || cnt_no !== 8'd1) begin
      n_errors++;
      $display("FAIL overlap_cnt: got ov=%0d no=%0d required ov=2 no=1", cnt_ov, cnt_no);
    end
  endtask

  task automatic test_en_gap();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (det_ov !== 1'b0) begin
        n_errors++;
        $display("FAIL en_gap_idle cyc%0d: got %b required 0", i, det_ov);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (det_ov !== 1'b1 || cnt_ov !== 8'd1) begin
      n_errors++;
      $display("FAIL en_gap_match: got det=%b cnt=%0d required det=1 cnt=1", det_ov, cnt_ov);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'(i % 2), 1'b0, 1'b0);
      n_checks++;
      if (det_ov !== 1'b1 || det_no !== 1'b1 || cnt_ov !== 8'd1) begin
        n_errors++;
        $display("FAIL en_gap_hold cyc%0d: got det=%b/%b cnt=%0d required det=1/1 cnt=1",
                 i, det_ov, det_no, cnt_ov);
      end
    end
  endtask

  task automatic test_saturate();
    int exp_c2;
    do_reset();
    for (int m = 0; m < 5; m++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (det_c2 !== 1'b0) begin
        n_errors++;
        $display("FAIL sat_mid match%0d: got det=%b required 0", m + 1, det_c2);
      end
      step(1'b1, 1'b1, 1'b0);
      exp_c2 = (m + 1 > 3) ? 3 : m + 1;
      n_checks++;
      if (det_c2 !== 1'b1 || int'(cnt_c2) !== exp_c2 || sat_c2 !== (m >= 2) ||
          int'(cnt_ov) !== m + 1) begin
        n_errors++;
        $display("FAIL sat_count match%0d: got det=%b cnt=%0d sat=%b cnt8=%0d required det=1 cnt=%0d sat=%b cnt8=%0d",
                 m + 1, det_c2, cnt_c2, sat_c2, cnt_ov, exp_c2, (m >= 2), m + 1);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (det_c2 !== 1'b1 || cnt_c2 !== 2'd1 || sat_c2 !== 1'b0 || cnt_ov !== 8'd1) begin
      n_errors++;
      $display("FAIL clr_with_match: got det=%b cnt=%0d sat=%b cnt8=%0d required det=1 cnt=1 sat=0 cnt8=1",
               det_c2, cnt_c2, sat_c2, cnt_ov);
    end
    step(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (det_c2 !== 1'b1 || cnt_c2 !== 2'd0 || cnt_ov !== 8'd0) begin
      n_errors++;
      $display("FAIL clr_idle: got det=%b cnt=%0d cnt8=%0d required det=1 cnt=0 cnt8=0",
               det_c2, cnt_c2, cnt_ov);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq;
    do_reset();
    seq = 4'b1101;
    for (int i = 3; i >= 0; i--) step(seq[i], 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (det_ov !== 1'b0 || cnt_ov !== 8'd0) begin
      n_errors++;
      $display("FAIL async_reset: got det=%b cnt=%0d required det=0 cnt=0", det_ov, cnt_ov);
    end
    #1 rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (det_ov !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_first: got det=%b required 0", det_ov);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (det_ov !== 1'b1 || cnt_ov !== 8'd1) begin
      n_errors++;
      $display("FAIL post_reset_match: got det=%b cnt=%0d required det=1 cnt=1", det_ov, cnt_ov);
    end
  endtask

  task automatic test_ones();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (det_t3o !== (i >= 3) || det_t3n !== (i % 3 == 0)) begin
        n_errors++;
        $display("FAIL ones_det bit%0d: got ov=%b no=%b required ov=%b no=%b",
                 i, det_t3o, det_t3n, (i >= 3), (i % 3 == 0));
      end
    end
    n_checks++;
    if (cnt_t3o !== 8'd8 || cnt_t3n !== 8'd3) begin
      n_errors++;
      $display("FAIL ones_cnt: got ov=%0d no=%0d required ov=8 no=3", cnt_t3o, cnt_t3n);
    end
  endtask

  task automatic test_random();
    logic xb, enb, clr;
    do_reset();
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      xb  = 1'($urandom_range(0, 1));
      enb = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step(xb, enb, clr);
      model_step(xb, enb, clr);
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (dut_det[i] !== m_det[i] || dut_cnt[i] !== m_cnt[i] ||
            dut_sat[i] !== (m_cnt[i] == m_max[i])) begin
          n_errors++;
          $display("FAIL random cyc%0d inst%0d: got det=%b cnt=%0d sat=%b required det=%b cnt=%0d sat=%b",
                   n, i, dut_det[i], dut_cnt[i], dut_sat[i], m_det[i], m_cnt[i],
                   (m_cnt[i] == m_max[i]));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; x = 1'b0; en = 1'b0; clr_count = 1'b0;
    #1 rst = 1'b0;
    test_reset();
    test_overlap();
    test_en_gap();
    test_saturate();
    test_reset_mid();
    test_ones();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
